// File: rtl/bellek_hakem_pkg.sv
// bellek_hakem_pkg
//   Shared constants and types for the two-requester memory arbiter.
//   HAKEM_ID_BIT   : width of a requester ID stored per outstanding read
//   HAKEM_VYD      : index of the bus controller requester
//   HAKEM_IKINCIL  : index of the secondary master requester
//   BEKLEYEN_DERINLIK_VARSAYILAN : default outstanding-read depth
package bellek_hakem_pkg;

  localparam int HAKEM_ID_BIT                 = 1;
  localparam int HAKEM_VYD                    = 0;
  localparam int HAKEM_IKINCIL                = 1;
  localparam int BEKLEYEN_DERINLIK_VARSAYILAN = 4;

  typedef logic [HAKEM_ID_BIT-1:0] hakem_id_t;

  // Request slot occupancy toward memory.
  typedef enum logic {
    BOS  = 1'b0,
    DOLU = 1'b1
  } slot_durum_e;

endpackage

// File: rtl/bellek_hakem_kimlik_fifo.sv
// bellek_hakem_kimlik_fifo
//   Synchronous FIFO of requester IDs, one entry per outstanding read.
//   Ports:
//     clk_i, rst_i : clock, synchronous active-high reset
//     it_i, it_id_i: push strobe and the ID to store (ignored when full)
//     cek_i        : pop strobe (ignored when empty)
//     bas_o        : ID at the head of the FIFO
//     dolu_o/bos_o : full / empty flags
//     sayac_o      : number of stored entries, 0..DERINLIK
//   DERINLIK must be a power of two so the pointers wrap on their own.
module bellek_hakem_kimlik_fifo
  import bellek_hakem_pkg::*;
#(
  parameter  int DERINLIK  = BEKLEYEN_DERINLIK_VARSAYILAN,
  localparam int PTR_BIT   = $clog2(DERINLIK),
  localparam int SAYAC_BIT = $clog2(DERINLIK + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 it_i,
  input  hakem_id_t            it_id_i,
  input  logic                 cek_i,
  output hakem_id_t            bas_o,
  output logic                 dolu_o,
  output logic                 bos_o,
  output logic [SAYAC_BIT-1:0] sayac_o
);

  hakem_id_t            kimlik_q [DERINLIK];
  logic [PTR_BIT-1:0]   yaz_ptr_q;
  logic [PTR_BIT-1:0]   oku_ptr_q;
  logic [SAYAC_BIT-1:0] sayac_q;
  logic                 it_gecerli;
  logic                 cek_gecerli;

  assign dolu_o      = (sayac_q == SAYAC_BIT'(DERINLIK));
  assign bos_o       = (sayac_q == {SAYAC_BIT{1'b0}});
  assign sayac_o     = sayac_q;
  assign bas_o       = kimlik_q[oku_ptr_q];
  // Push looks only at the registered count: a same-cycle pop frees nothing.
  assign it_gecerli  = it_i & ~dolu_o;
  assign cek_gecerli = cek_i & ~bos_o;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yaz_ptr_q <= {PTR_BIT{1'b0}};
      oku_ptr_q <= {PTR_BIT{1'b0}};
      sayac_q   <= {SAYAC_BIT{1'b0}};
      for (int i = 0; i < DERINLIK; i++) begin
        kimlik_q[i] <= {HAKEM_ID_BIT{1'b0}};
      end
    end else begin
      if (it_gecerli) begin
        kimlik_q[yaz_ptr_q] <= it_id_i;
        yaz_ptr_q           <= yaz_ptr_q + PTR_BIT'(1);
      end
      if (cek_gecerli) begin
        oku_ptr_q <= oku_ptr_q + PTR_BIT'(1);
      end
      case ({it_gecerli, cek_gecerli})
        2'b10:   sayac_q <= sayac_q + SAYAC_BIT'(1);
        2'b01:   sayac_q <= sayac_q - SAYAC_BIT'(1);
        default: sayac_q <= sayac_q;
      endcase
    end
  end

endmodule

// File: rtl/bellek_hakem.sv
// bellek_hakem
//   Two-requester arbiter in front of the single main-memory port.
//   Requester 0 = bus controller, requester 1 = secondary master.
//   Requests are granted round-robin into a one-deep registered slice;
//   read responses return in order and are routed by an ID FIFO.
//   Ports:
//     m_istek_*   : per-requester request channel (slice i = requester i)
//     m_veri_*    : read-data channel, data broadcast, valid one-hot
//     mem_istek_* : registered request channel toward memory
//     mem_veri_*  : read-data channel from memory
//   Build option: BELLEK_HAKEM_SABIT_ONCELIK_EN selects fixed priority
//   (requester 0 wins ties) instead of round-robin.
module bellek_hakem
  import bellek_hakem_pkg::*;
#(
  parameter int ADRES_BIT         = 32,
  parameter int VERI_BIT          = 32,
  parameter int BEKLEYEN_DERINLIK = BEKLEYEN_DERINLIK_VARSAYILAN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2*ADRES_BIT-1:0] m_istek_adres_i,
  input  logic [2*VERI_BIT-1:0]  m_istek_veri_i,
  input  logic [1:0]             m_istek_yaz_i,
  input  logic [1:0]             m_istek_gecerli_i,
  output logic [1:0]             m_istek_hazir_o,
  output logic [VERI_BIT-1:0]    m_veri_o,
  output logic [1:0]             m_veri_gecerli_o,
  input  logic [1:0]             m_veri_hazir_i,
  output logic [ADRES_BIT-1:0]   mem_istek_adres_o,
  output logic [VERI_BIT-1:0]    mem_istek_veri_o,
  output logic                   mem_istek_yaz_o,
  output logic                   mem_istek_gecerli_o,
  input  logic                   mem_istek_hazir_i,
  input  logic [VERI_BIT-1:0]    mem_veri_i,
  input  logic                   mem_veri_gecerli_i,
  output logic                   mem_veri_hazir_o
);

  localparam int SAYAC_BIT = $clog2(BEKLEYEN_DERINLIK + 1);

  slot_durum_e           durum_q, durum_d;
  logic [ADRES_BIT-1:0]  adres_q, adres_d;
  logic [VERI_BIT-1:0]   veri_q, veri_d;
  logic                  yaz_q, yaz_d;
  logic                  son_q, son_d;

  logic                  tercih;
  logic                  kazanan;
  logic                  kabul;
  logic                  istek_hs;
  logic                  fifo_it;
  logic                  fifo_cek;
  hakem_id_t             bas_id;
  logic                  fifo_dolu;
  logic                  fifo_bos;
  logic [SAYAC_BIT-1:0]  sayac;
  logic                  izleme_unused;

  // Count and last-grant are kept for observation; son_q is idle in fixed mode.
  assign izleme_unused = ^{sayac, son_q};

  // Arbitration: pick the winner, then compute request ready and handshake.
  always_comb begin
    tercih = 1'b0;
    case (m_istek_gecerli_i)
`ifdef BELLEK_HAKEM_SABIT_ONCELIK_EN
      2'b11:   tercih = 1'b0;
`else
      2'b11:   tercih = ~son_q;
`endif
      2'b10:   tercih = 1'b1;
      2'b01:   tercih = 1'b0;
      default: tercih = 1'b0;
    endcase

    // A read stuck on a full ID FIFO must not starve a write from the other side.
    if (fifo_dolu && m_istek_gecerli_i[tercih] && !m_istek_yaz_i[tercih] &&
        m_istek_gecerli_i[~tercih] && m_istek_yaz_i[~tercih]) begin
      kazanan = ~tercih;
    end else begin
      kazanan = tercih;
    end

    kabul           = (durum_q == BOS) | mem_istek_hazir_i;
    m_istek_hazir_o = 2'b00;
    if (!rst_i && kabul && (m_istek_yaz_i[kazanan] || !fifo_dolu)) begin
      m_istek_hazir_o[kazanan] = 1'b1;
    end else begin
      m_istek_hazir_o = 2'b00;
    end

    istek_hs = m_istek_gecerli_i[kazanan] & m_istek_hazir_o[kazanan];
    fifo_it  = istek_hs & ~m_istek_yaz_i[kazanan];
  end

  // Next state of the request slot and the round-robin pointer.
  always_comb begin
    durum_d = durum_q;
    adres_d = adres_q;
    veri_d  = veri_q;
    yaz_d   = yaz_q;
    son_d   = son_q;
    if (istek_hs) begin
      durum_d = DOLU;
      adres_d = kazanan ? m_istek_adres_i[2*ADRES_BIT-1:ADRES_BIT]
                        : m_istek_adres_i[ADRES_BIT-1:0];
      veri_d  = kazanan ? m_istek_veri_i[2*VERI_BIT-1:VERI_BIT]
                        : m_istek_veri_i[VERI_BIT-1:0];
      yaz_d   = m_istek_yaz_i[kazanan];
      son_d   = kazanan;
    end else if (kabul) begin
      durum_d = BOS;
    end else begin
      durum_d = durum_q;
    end
  end

  // Response routing by the FIFO head; nothing is acknowledged with no reads pending.
  always_comb begin
    m_veri_gecerli_o = 2'b00;
    mem_veri_hazir_o = 1'b0;
    if (!rst_i && !fifo_bos) begin
      m_veri_gecerli_o[bas_id] = mem_veri_gecerli_i;
      mem_veri_hazir_o         = m_veri_hazir_i[bas_id];
    end else begin
      m_veri_gecerli_o = 2'b00;
      mem_veri_hazir_o = 1'b0;
    end
    fifo_cek = mem_veri_gecerli_i & mem_veri_hazir_o;
  end

  // Slot and round-robin registers; son_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q <= BOS;
      adres_q <= {ADRES_BIT{1'b0}};
      veri_q  <= {VERI_BIT{1'b0}};
      yaz_q   <= 1'b0;
      son_q   <= 1'b1;
    end else begin
      durum_q <= durum_d;
      adres_q <= adres_d;
      veri_q  <= veri_d;
      yaz_q   <= yaz_d;
      son_q   <= son_d;
    end
  end

  assign mem_istek_gecerli_o = (durum_q == DOLU);
  assign mem_istek_adres_o   = adres_q;
  assign mem_istek_veri_o    = veri_q;
  assign mem_istek_yaz_o     = yaz_q;
  assign m_veri_o            = mem_veri_i;

  bellek_hakem_kimlik_fifo #(
    .DERINLIK (BEKLEYEN_DERINLIK)
  ) u_kimlik_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .it_i    (fifo_it),
    .it_id_i (kazanan),
    .cek_i   (fifo_cek),
    .bas_o   (bas_id),
    .dolu_o  (fifo_dolu),
    .bos_o   (fifo_bos),
    .sayac_o (sayac)
  );

endmodule
